// File: rtl/goldschmidt_sched_pkg.sv
// ---------------------------------------------------------------------------
// gs_pkg -- shared types and constants for the Goldschmidt divider scheduler.
//
// Contents:
//   state_t    : scheduler states (IDLE, RUN, DONE)
//   K0         : initial reciprocal estimate 0.75, Q1.28 fixed point
//   step_t     : RUN step counter type, wide enough for 2*ITER_MAX+1
//   last_step(): index of the final RUN step for a given iteration count
//
// Optional feature macro used by the files importing this package:
//   GS_DIVZERO_EN -- divide-by-zero short-cut with rsp_dz flag
// ---------------------------------------------------------------------------
package gs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 0.75 with 28 fractional bits
    localparam int          K0_FRAC_BITS = 28;
    localparam logic [28:0] K0           = 29'h0C00_0000;

    localparam int ITER_MAX = 7;
    // Steps run 0..2*ITER+1, so the counter must hold 2*ITER_MAX+1 = 15.
    localparam int STEP_W   = $clog2(2 * ITER_MAX + 2);

    typedef logic [STEP_W-1:0] step_t;

    function automatic step_t last_step(input int iter);
        return step_t'(2 * iter + 1);
    endfunction

endpackage

// File: rtl/goldschmidt_sched_if.sv
// ---------------------------------------------------------------------------
// goldschmidt_sched_if -- bundle of all handshake / datapath signals of the
// Goldschmidt scheduler.
//
// Signals:
//   a_valid/a_ready/a_num/a_den : requester A
//   b_valid/b_ready/b_num/b_den : requester B
//   dp_mode/dp_stage/dp_num/dp_den/dp_quot : datapath control and operands
//   rsp_valid/rsp_ready/rsp_quot/rsp_id    : response channel (id 0=A, 1=B)
//   rsp_dz : divide-by-zero flag, present only with GS_DIVZERO_EN defined
//
// Modports:
//   slave  : the scheduler side
//   master : requesters / datapath / response consumer side
// ---------------------------------------------------------------------------
interface goldschmidt_sched_if #(
    parameter int WIDTH = 29
);
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_num;
    logic [WIDTH-1:0] a_den;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_num;
    logic [WIDTH-1:0] b_den;

    logic             dp_mode;
    logic             dp_stage;
    logic [WIDTH-1:0] dp_num;
    logic [WIDTH-1:0] dp_den;
    logic [WIDTH-1:0] dp_quot;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quot;
    logic             rsp_id;
`ifdef GS_DIVZERO_EN
    logic             rsp_dz;
`endif

    modport slave (
        input  a_valid, a_num, a_den,
        input  b_valid, b_num, b_den,
        input  dp_quot, rsp_ready,
        output a_ready, b_ready,
        output dp_mode, dp_stage, dp_num, dp_den,
        output rsp_valid, rsp_quot, rsp_id
`ifdef GS_DIVZERO_EN
        , output rsp_dz
`endif
    );

    modport master (
        output a_valid, a_num, a_den,
        output b_valid, b_num, b_den,
        output dp_quot, rsp_ready,
        input  a_ready, b_ready,
        input  dp_mode, dp_stage, dp_num, dp_den,
        input  rsp_valid, rsp_quot, rsp_id
`ifdef GS_DIVZERO_EN
        , input rsp_dz
`endif
    );

endinterface

// File: rtl/goldschmidt_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 -- two-way round-robin arbiter.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector (bit 0 = A, bit 1 = B)
//   advance    : a grant was consumed this cycle; hand favour to the loser
//   gnt[1:0]   : one-hot grant (zero when no request)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0 = A favoured, 1 = B favoured
    logic favour_reg;

    // A lone requester always wins; favour only breaks ties.
    assign gnt = (req == 2'b11) ? (favour_reg ? 2'b10 : 2'b01) : req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour_reg <= 1'b0;
        end else if (advance) begin
            // If A was served, B is favoured next, and vice versa.
            favour_reg <= gnt[0];
        end
    end

endmodule

// File: rtl/goldschmidt_sched.sv
// ---------------------------------------------------------------------------
// goldschmidt_sched -- sequences one Goldschmidt division at a time for two
// requesters, driving the datapath mode/stage for 2*ITER+2 cycles and then
// presenting the captured quotient on the response channel.
//
// Parameters:
//   WIDTH : operand / quotient width (default 29)
//   ITER  : refinement iterations, 1..7 (default 5)
//
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : goldschmidt_sched_if.slave (requesters A/B, datapath, response)
//
// Optional feature: define GS_DIVZERO_EN to short-cut den==0 requests straight
// to DONE with an all-ones quotient and rsp_dz=1.
// ---------------------------------------------------------------------------
module goldschmidt_sched
    import gs_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int ITER  = 5
) (
    input  logic                clk,
    input  logic                reset,
    goldschmidt_sched_if.slave  bus
);

    localparam step_t LAST = last_step(ITER);

    state_t           state_reg;
    step_t            step_reg;
    logic             dp_mode_reg;
    logic             dp_stage_reg;
    logic [WIDTH-1:0] dp_num_reg;
    logic [WIDTH-1:0] dp_den_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_quot_reg;
    logic             rsp_id_reg;
`ifdef GS_DIVZERO_EN
    logic             rsp_dz_reg;
`endif

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             accept;
    logic             sel_b;
    logic [WIDTH-1:0] acc_num;
    logic [WIDTH-1:0] acc_den;
    step_t            step_next;

    // Requests are only presented to the arbiter in IDLE, so ready is low
    // (and the requester simply waits) during RUN and DONE.
    assign req = (state_reg == ST_IDLE) ? {bus.b_valid, bus.a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    assign bus.a_ready = gnt[0];
    assign bus.b_ready = gnt[1];
    assign accept      = |gnt;
    assign sel_b       = gnt[1];
    assign acc_num     = sel_b ? bus.b_num : bus.a_num;
    assign acc_den     = sel_b ? bus.b_den : bus.a_den;
    assign step_next   = step_reg + step_t'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            step_reg      <= '0;
            dp_mode_reg   <= 1'b0;
            dp_stage_reg  <= 1'b0;
            dp_num_reg    <= '0;
            dp_den_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_quot_reg  <= '0;
            rsp_id_reg    <= 1'b0;
`ifdef GS_DIVZERO_EN
            rsp_dz_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        dp_num_reg   <= acc_num;
                        dp_den_reg   <= acc_den;
                        rsp_id_reg   <= sel_b;
                        step_reg     <= '0;
                        // Step 0 drives mode=0, stage=0.
                        dp_mode_reg  <= 1'b0;
                        dp_stage_reg <= 1'b0;
`ifdef GS_DIVZERO_EN
                        if (acc_den == '0) begin
                            state_reg     <= ST_DONE;
                            rsp_valid_reg <= 1'b1;
                            rsp_quot_reg  <= '1;
                            rsp_dz_reg    <= 1'b1;
                        end else begin
                            state_reg     <= ST_RUN;
                            rsp_dz_reg    <= 1'b0;
                        end
`else
                        state_reg    <= ST_RUN;
`endif
                    end
                end

                ST_RUN: begin
                    if (step_reg == LAST) begin
                        state_reg     <= ST_DONE;
                        rsp_valid_reg <= 1'b1;
                        rsp_quot_reg  <= bus.dp_quot;
                        dp_mode_reg   <= 1'b0;
                        dp_stage_reg  <= 1'b0;
                    end else begin
                        step_reg      <= step_next;
                        // Registered look-ahead: outputs reflect the step
                        // that is current after this edge.
                        dp_mode_reg   <= (step_next >= step_t'(2));
                        dp_stage_reg  <= step_next[0];
                    end
                end

                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dp_mode   = dp_mode_reg;
    assign bus.dp_stage  = dp_stage_reg;
    assign bus.dp_num    = dp_num_reg;
    assign bus.dp_den    = dp_den_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_quot  = rsp_quot_reg;
    assign bus.rsp_id    = rsp_id_reg;
`ifdef GS_DIVZERO_EN
    assign bus.rsp_dz    = rsp_dz_reg;
`endif

endmodule
